// File: rtl/eth_helper_pkg.sv
// eth_helper_pkg
//   Shared definitions for the EthHelper stream encoders and decoders:
//   - decoder FSM state encoding for the R-channel stream decoder
//   - bit offsets of the fixed fields inside the R metadata word
//   - stream type tags, shared with the encoder side so both ends agree
package eth_helper_pkg;

  // Decoder state: waiting for the data word, waiting for the metadata
  // word, or presenting the regenerated beat on the AXI R channel.
  typedef enum logic [1:0] {
    S_DATA = 2'd0,
    S_META = 2'd1,
    S_OUT  = 2'd2
  } r_dec_state_e;

  // Fixed fields at the bottom of the metadata word. RID starts at
  // META_RID_LSB and RUSER follows directly above RID, so the RUSER
  // offset depends on ID_WIDTH and is derived inside the users.
  localparam int META_RRESP_LSB = 0;
  localparam int META_RRESP_W   = 2;
  localparam int META_RLAST_BIT = 2;
  localparam int META_RID_LSB   = 3;

  // Stream type tags carried next to every stream word.
  localparam int          STREAM_TYPE_W  = 3;
  localparam logic [2:0]  STREAM_TYPE_R  = 3'd0;
  localparam logic [2:0]  STREAM_TYPE_AR = 3'd1;
  localparam logic [2:0]  STREAM_TYPE_AW = 3'd2;
  localparam logic [2:0]  STREAM_TYPE_W_ = 3'd3;
  localparam logic [2:0]  STREAM_TYPE_B  = 3'd4;

endpackage

// File: rtl/r_burst_checker.sv
// r_burst_checker
//   Watches the beats handed off on the regenerated AXI R channel and raises
//   a sticky error when a burst does not look like BURST_LEN beats with one
//   RID and RLAST on the final beat only. Purely observational.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   beat_fire  in   one R beat handed off this cycle (rvalid && rready)
//   beat_last  in   RLAST of that beat
//   beat_id    in   RID of that beat
//   burst_err  out  sticky protocol error, cleared only by reset
module r_burst_checker #(
  parameter int BURST_LEN = 8,
  parameter int ID_WIDTH  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                beat_fire,
  input  logic                beat_last,
  input  logic [ID_WIDTH-1:0] beat_id,
  output logic                burst_err
);

  // A one-beat burst still needs a one-bit counter to exist.
  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(BURST_LEN - 1);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [ID_WIDTH-1:0] first_id_q, first_id_d;
  logic                err_q, err_d;

  always_comb begin
    cnt_d      = cnt_q;
    first_id_d = first_id_q;
    err_d      = err_q;
    if (beat_fire) begin
      if (beat_last && (cnt_q != LAST_IDX)) begin
        err_d = 1'b1;
      end
      if (!beat_last && (cnt_q == LAST_IDX)) begin
        err_d = 1'b1;
      end
      // The first beat defines the burst's RID; later beats must match it.
      if (cnt_q == '0) begin
        first_id_d = beat_id;
      end else if (beat_id != first_id_q) begin
        err_d = 1'b1;
      end
      // Restart on RLAST; also restart after the last index so a missing
      // RLAST does not leave the counter walking past the burst length.
      if (beat_last || (cnt_q == LAST_IDX)) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      first_id_q <= '0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      first_id_q <= first_id_d;
      err_q      <= err_d;
    end
  end

  assign burst_err = err_q;

endmodule

// File: rtl/stream_to_axi_r.sv
// stream_to_axi_r
//   Rebuilds AXI R-channel beats from the captured two-word-per-beat stream:
//   a data word followed by a metadata word holding RRESP/RLAST/RID/RUSER.
//   Only words tagged with STREAM_TYPE are consumed; other tags are left
//   waiting on the stream (stream_ready stays low for them).
//
//   Optional feature: define STREAM_TO_AXI_R_CHECK_EN to instantiate the
//   burst checker driving burst_err; otherwise burst_err is tied low.
//
// Ports:
//   clk, reset                     clock and synchronous active-high reset
//   stream_valid/ready/data/type   incoming stream words
//   busy                           beat partially received or being driven
//   AXIM_r*                        regenerated AXI R channel (master side)
//   burst_err                      sticky burst protocol error
module stream_to_axi_r
  import eth_helper_pkg::*;
#(
  parameter int DATA_WIDTH        = 128,
  parameter int ID_WIDTH          = 32,
  parameter int USER_WIDTH        = 64,
  parameter int BURST_LEN         = 8,
  parameter int STREAM_TYPE_WIDTH = 3,
  parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE = STREAM_TYPE_WIDTH'(STREAM_TYPE_R)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stream_valid,
  output logic                         stream_ready,
  input  logic [DATA_WIDTH-1:0]        stream_data,
  input  logic [STREAM_TYPE_WIDTH-1:0] stream_type,
  output logic                         busy,
  output logic [ID_WIDTH-1:0]          AXIM_rid,
  output logic [DATA_WIDTH-1:0]        AXIM_rdata,
  output logic [1:0]                   AXIM_rresp,
  output logic                         AXIM_rlast,
  output logic [USER_WIDTH-1:0]        AXIM_ruser,
  output logic                         AXIM_rvalid,
  input  logic                         AXIM_rready,
  output logic                         burst_err
);

  localparam int RID_LSB   = META_RID_LSB;
  localparam int RUSER_LSB = META_RID_LSB + ID_WIDTH;

  generate
    if (ID_WIDTH + USER_WIDTH + 3 > DATA_WIDTH) begin : g_width_check
      $error("stream_to_axi_r: metadata fields do not fit in DATA_WIDTH");
    end
  endgenerate

  r_dec_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rlast_q, rlast_d;
  logic [USER_WIDTH-1:0] ruser_q, ruser_d;
  logic                  rvalid_q, rvalid_d;

  logic type_match;
  logic accept;

  assign type_match = (stream_type == STREAM_TYPE);

  // While a beat is on the R channel a new word may only be taken in the
  // cycle the beat leaves, so at most one beat is ever held.
  always_comb begin
    stream_ready = 1'b0;
    if (!reset && type_match) begin
      unique case (state_q)
        S_DATA:  stream_ready = 1'b1;
        S_META:  stream_ready = 1'b1;
        S_OUT:   stream_ready = AXIM_rready;
        default: stream_ready = 1'b0;
      endcase
    end
  end

  assign accept = stream_valid && stream_ready;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    rid_d    = rid_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;
    ruser_d  = ruser_q;
    rvalid_d = rvalid_q;
    unique case (state_q)
      S_DATA: begin
        if (accept) begin
          data_d  = stream_data;
          state_d = S_META;
        end
      end
      S_META: begin
        if (accept) begin
          rdata_d  = data_q;
          rresp_d  = stream_data[META_RRESP_LSB +: META_RRESP_W];
          rlast_d  = stream_data[META_RLAST_BIT];
          rid_d    = stream_data[RID_LSB +: ID_WIDTH];
          ruser_d  = stream_data[RUSER_LSB +: USER_WIDTH];
          rvalid_d = 1'b1;
          state_d  = S_OUT;
        end
      end
      S_OUT: begin
        // Output fields stay loaded after the handshake; only valid drops.
        if (AXIM_rready) begin
          rvalid_d = 1'b0;
          if (accept) begin
            data_d  = stream_data;
            state_d = S_META;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      default: begin
        state_d  = S_DATA;
        rvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_DATA;
      data_q   <= '0;
      rdata_q  <= '0;
      rid_q    <= '0;
      rresp_q  <= '0;
      rlast_q  <= 1'b0;
      ruser_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      rdata_q  <= rdata_d;
      rid_q    <= rid_d;
      rresp_q  <= rresp_d;
      rlast_q  <= rlast_d;
      ruser_q  <= ruser_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign busy        = (state_q == S_META) || (state_q == S_OUT);
  assign AXIM_rdata  = rdata_q;
  assign AXIM_rid    = rid_q;
  assign AXIM_rresp  = rresp_q;
  assign AXIM_rlast  = rlast_q;
  assign AXIM_ruser  = ruser_q;
  assign AXIM_rvalid = rvalid_q;

`ifdef STREAM_TO_AXI_R_CHECK_EN
  r_burst_checker #(
    .BURST_LEN (BURST_LEN),
    .ID_WIDTH  (ID_WIDTH)
  ) u_burst_checker (
    .clk       (clk),
    .reset     (reset),
    .beat_fire (rvalid_q && AXIM_rready),
    .beat_last (rlast_q),
    .beat_id   (rid_q),
    .burst_err (burst_err)
  );
`else
  assign burst_err = 1'b0;
`endif

endmodule

// File: tb/tb_stream_to_axi_r.sv
// tb_stream_to_axi_r
//   Bench for stream_to_axi_r with default parameters. Inputs change on the
//   falling edge and outputs are compared shortly after, against a model of
//   the decoder kept as "held data word" / "beat on the bus" occupancy plus
//   a burst-rule checker that mirrors the documented error conditions.
module tb_stream_to_axi_r;
  localparam int DW = 128;
  localparam int IW = 32;
  localparam int UW = 64;
  localparam int BL = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          stream_valid;
  logic          stream_ready;
  logic [DW-1:0] stream_data;
  logic [2:0]    stream_type;
  logic          busy;
  logic [IW-1:0] AXIM_rid;
  logic [DW-1:0] AXIM_rdata;
  logic [1:0]    AXIM_rresp;
  logic          AXIM_rlast;
  logic [UW-1:0] AXIM_ruser;
  logic          AXIM_rvalid;
  logic          AXIM_rready;
  logic          burst_err;

  stream_to_axi_r dut (
    .clk          (clk),
    .reset        (reset),
    .stream_valid (stream_valid),
    .stream_ready (stream_ready),
    .stream_data  (stream_data),
    .stream_type  (stream_type),
    .busy         (busy),
    .AXIM_rid     (AXIM_rid),
    .AXIM_rdata   (AXIM_rdata),
    .AXIM_rresp   (AXIM_rresp),
    .AXIM_rlast   (AXIM_rlast),
    .AXIM_ruser   (AXIM_ruser),
    .AXIM_rvalid  (AXIM_rvalid),
    .AXIM_rready  (AXIM_rready),
    .burst_err    (burst_err)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;
  int dutFires    = 0;

  // Reference model state
  logic          mHave;
  logic [DW-1:0] mHeld;
  logic          mValid;
  logic [DW-1:0] mData;
  logic [IW-1:0] mId;
  logic [1:0]    mResp;
  logic          mLast;
  logic [UW-1:0] mUser;
  logic          mErr;
  int            mIdx;
  logic [IW-1:0] mFirstId;
  logic          mReady;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic [2:0]    t;
    logic          rr;
    logic          expReady;
    logic          expValid;
    logic          expBusy;
  } vec_t;

  vec_t vecs[17];

  function automatic logic [DW-1:0] mkMeta(input logic [UW-1:0] user, input logic [IW-1:0] id,
                                           input logic last, input logic [1:0] resp);
    logic [DW-1:0] w;
    w = '0;
    w[1:0] = resp;
    w[2] = last;
    w[3 +: IW] = id;
    w[3 + IW +: UW] = user;
    return w;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mHave = 0; mHeld = '0; mValid = 0; mData = '0; mId = '0; mResp = '0;
    mLast = 0; mUser = '0; mErr = 0; mIdx = 0; mFirstId = '0; mReady = 0;
  endtask

  task automatic driveInputs(input logic v, input logic [DW-1:0] d, input logic [2:0] t,
                             input logic rr);
    @(negedge clk);
    reset        = 1'b0;
    stream_valid = v;
    stream_data  = d;
    stream_type  = t;
    AXIM_rready  = rr;
    #1;
  endtask

  task automatic checkOutput();
    logic expErr;
    // A word is taken unless it has the wrong tag or a beat is stuck on the bus.
    mReady = (stream_type == 3'd0) && (!mValid || AXIM_rready);
`ifdef STREAM_TO_AXI_R_CHECK_EN
    expErr = mErr;
`else
    expErr = 1'b0;
`endif
    chk("stream_ready", DW'(stream_ready), DW'(mReady));
    chk("rvalid",       DW'(AXIM_rvalid),  DW'(mValid));
    chk("busy",         DW'(busy),         DW'(mHave || mValid));
    chk("rdata",        AXIM_rdata,        mData);
    chk("rid",          DW'(AXIM_rid),     DW'(mId));
    chk("rresp",        DW'(AXIM_rresp),   DW'(mResp));
    chk("rlast",        DW'(AXIM_rlast),   DW'(mLast));
    chk("ruser",        DW'(AXIM_ruser),   DW'(mUser));
    chk("burst_err",    DW'(burst_err),    DW'(expErr));
    if (AXIM_rvalid && AXIM_rready) dutFires++;
  endtask

  task automatic advanceClock();
    logic acc, fire;
    @(posedge clk);
    acc  = stream_valid && mReady;
    fire = mValid && AXIM_rready;
    if (fire) begin
      mValid = 0;
      if ((mLast && mIdx != BL-1) || (!mLast && mIdx == BL-1)) mErr = 1;
      if (mIdx == 0) mFirstId = mId;
      else if (mId != mFirstId) mErr = 1;
      mIdx = (mLast || mIdx == BL-1) ? 0 : mIdx + 1;
    end
    if (acc) begin
      if (!mHave) begin
        mHave = 1;
        mHeld = stream_data;
      end else begin
        mData  = mHeld;
        mResp  = stream_data[1:0];
        mLast  = stream_data[2];
        mId    = stream_data[3 +: IW];
        mUser  = stream_data[3 + IW +: UW];
        mValid = 1;
        mHave  = 0;
      end
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic [2:0] t,
                               input logic rr);
    driveInputs(v, d, t, rr);
    checkOutput();
    advanceClock();
  endtask

  // Reset is asserted with a valid, matching word on the stream so that
  // stream_ready being held low by reset is actually exercised.
  task automatic applyReset();
    @(negedge clk);
    reset        = 1'b1;
    stream_valid = 1'b1;
    stream_type  = 3'd0;
    stream_data  = '1;
    AXIM_rready  = 1'b1;
    #1;
    chk("ready_in_reset", DW'(stream_ready), DW'(0));
    @(posedge clk);
    modelReset();
  endtask

  task automatic sendBeat(input logic [DW-1:0] d, input logic [IW-1:0] id, input logic last);
    applyStimulus(1, d, 3'd0, 1);
    applyStimulus(1, mkMeta(UW'(id) ^ 64'h55, id, last, 2'(id)), 3'd0, 1);
  endtask

  initial begin
    logic [DW-1:0] a5, d2, d3, m1, m2, m3;
    a5 = {16{8'hA5}};
    d2 = {4{32'h1234_5678}};
    d3 = {4{32'hCAFE_F00D}};
    m1 = mkMeta(64'h1, 32'h7, 1'b1, 2'b00);
    m2 = mkMeta(64'hBEEF, 32'h9, 1'b0, 2'b10);
    m3 = mkMeta(64'hFACE, 32'hA, 1'b1, 2'b01);

    //           v  data  type  rr  ready valid busy
    vecs[0]  = '{1, a5,   3'd0, 1,  1,    0,    0};
    vecs[1]  = '{1, m1,   3'd0, 1,  1,    0,    1};
    vecs[2]  = '{0, '0,   3'd0, 1,  1,    1,    1};
    vecs[3]  = '{0, '0,   3'd0, 1,  1,    0,    0};
    vecs[4]  = '{1, d2,   3'd1, 1,  0,    0,    0};
    vecs[5]  = '{1, d2,   3'd1, 1,  0,    0,    0};
    vecs[6]  = '{1, d2,   3'd0, 1,  1,    0,    0};
    vecs[7]  = '{1, m2,   3'd0, 0,  1,    0,    1};
    vecs[8]  = '{1, d3,   3'd0, 0,  0,    1,    1};
    vecs[9]  = '{1, d3,   3'd0, 0,  0,    1,    1};
    vecs[10] = '{1, d3,   3'd0, 0,  0,    1,    1};
    vecs[11] = '{1, d3,   3'd0, 0,  0,    1,    1};
    vecs[12] = '{1, d3,   3'd0, 0,  0,    1,    1};
    vecs[13] = '{1, d3,   3'd0, 1,  1,    1,    1};
    vecs[14] = '{1, m3,   3'd0, 1,  1,    0,    1};
    vecs[15] = '{0, '0,   3'd0, 1,  1,    1,    1};
    vecs[16] = '{0, '0,   3'd0, 1,  1,    0,    0};

    reset = 1'b1; stream_valid = 0; stream_data = '0; stream_type = 3'd0; AXIM_rready = 0;
    modelReset();
    applyReset();
    applyReset();

    // Reset values
    driveInputs(0, '0, 3'd0, 0);
    chk("reset_rvalid", DW'(AXIM_rvalid), DW'(0));
    chk("reset_busy",   DW'(busy),        DW'(0));
    chk("reset_rdata",  AXIM_rdata,       DW'(0));
    chk("reset_err",    DW'(burst_err),   DW'(0));
    checkOutput();
    advanceClock();

    // Single beat, wrong tag, backpressure
    $display("[TB] table vectors");
    for (int i = 0; i < 17; i++) begin
      driveInputs(vecs[i].v, vecs[i].d, vecs[i].t, vecs[i].rr);
      checkOutput();
      chk($sformatf("vec%0d_ready", i), DW'(stream_ready), DW'(vecs[i].expReady));
      chk($sformatf("vec%0d_rvalid", i), DW'(AXIM_rvalid), DW'(vecs[i].expValid));
      chk($sformatf("vec%0d_busy", i), DW'(busy), DW'(vecs[i].expBusy));
      if (i == 2) begin
        chk("single_rdata", AXIM_rdata, a5);
        chk("single_rid", DW'(AXIM_rid), DW'(32'h7));
        chk("single_ruser", DW'(AXIM_ruser), DW'(64'h1));
        chk("single_rlast", DW'(AXIM_rlast), DW'(1));
      end
      if (i >= 8 && i <= 13) begin
        chk("bp_rdata", AXIM_rdata, d2);
        chk("bp_ruser", DW'(AXIM_ruser), DW'(64'hBEEF));
      end
      advanceClock();
    end

    // 8-beat burst, RID 3, no stalls anywhere
    $display("[TB] full burst");
    applyReset();
    dutFires = 0;
    for (int b = 0; b < BL; b++) sendBeat(DW'(b) * 128'h1111, 32'h3, b == BL-1);
    applyStimulus(0, '0, 3'd0, 1);
    applyStimulus(0, '0, 3'd0, 1);
    chk("burst_beats", DW'(dutFires), DW'(BL));
    chk("burst_clean_err", DW'(burst_err), DW'(0));

    // Reset while waiting for the metadata word
    $display("[TB] reset in meta");
    applyStimulus(1, d3, 3'd0, 1);
    applyReset();
    driveInputs(0, '0, 3'd0, 1);
    chk("rst_meta_rvalid", DW'(AXIM_rvalid), DW'(0));
    chk("rst_meta_busy", DW'(busy), DW'(0));
    checkOutput();
    advanceClock();
    sendBeat(d2, 32'h3, 1'b0);
    driveInputs(0, '0, 3'd0, 0);
    chk("rst_meta_next_rdata", AXIM_rdata, d2);
    chk("rst_meta_next_rvalid", DW'(AXIM_rvalid), DW'(1));
    checkOutput();
    advanceClock();
    applyStimulus(0, '0, 3'd0, 1);

    // Early RLAST on beat 5
    $display("[TB] early rlast");
    applyReset();
    for (int b = 0; b < 5; b++) sendBeat(DW'(b + 40), 32'h3, b == 4);
    for (int k = 0; k < 4; k++) applyStimulus(0, '0, 3'd0, 1);
`ifdef STREAM_TO_AXI_R_CHECK_EN
    chk("early_rlast_err", DW'(burst_err), DW'(1));
`else
    chk("early_rlast_err", DW'(burst_err), DW'(0));
`endif
    applyReset();
    driveInputs(0, '0, 3'd0, 1);
    chk("err_cleared", DW'(burst_err), DW'(0));
    checkOutput();
    advanceClock();

    // Random traffic against the model
    $display("[TB] random traffic");
    for (int c = 0; c < 600; c++) begin
      logic [DW-1:0] w;
      w = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus($urandom_range(0, 9) < 7, w,
                    ($urandom_range(0, 4) == 0) ? 3'd1 : 3'd0,
                    $urandom_range(0, 9) < 6);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
